// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe
// Brief    : MIPS32 logic/shift/nop decode with prioritised forwarding, load-use
//            stall and ID/EX register. Define ID_PIPE_FWD_EN to enable bypass.
// Revision : 1.0
// ============================================================================
module id_pipe #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int FWD_PORTS = 2
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             pc_i,
   input  logic [31:0]                   inst_i,
   output logic                          reg1_read_o,
   output logic                          reg2_read_o,
   output logic [REG_AW-1:0]             reg1_addr_o,
   output logic [REG_AW-1:0]             reg2_addr_o,
   input  logic [DATA_W-1:0]             reg1_data_i,
   input  logic [DATA_W-1:0]             reg2_data_i,
   input  logic [FWD_PORTS-1:0]          fwd_wreg_i,
   input  logic [FWD_PORTS-1:0]          fwd_load_i,
   input  logic [FWD_PORTS*REG_AW-1:0]   fwd_wd_i,
   input  logic [FWD_PORTS*DATA_W-1:0]   fwd_wdata_i,
   input  logic                          flush_i,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    aluop_o,
   output logic [2:0]                    alusel_o,
   output logic [DATA_W-1:0]             reg1_o,
   output logic [DATA_W-1:0]             reg2_o,
   output logic [REG_AW-1:0]             wd_o,
   output logic                          wreg_o,
   output logic [DATA_W-1:0]             pc_o,
   output logic                          inst_invalid_o
);

   localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
   localparam logic [5:0] c_OP_ANDI    = 6'b001100;
   localparam logic [5:0] c_OP_ORI     = 6'b001101;
   localparam logic [5:0] c_OP_XORI    = 6'b001110;
   localparam logic [5:0] c_OP_LUI     = 6'b001111;
   localparam logic [5:0] c_OP_PREF    = 6'b110011;

   localparam logic [5:0] c_FN_SLL     = 6'b000000;
   localparam logic [5:0] c_FN_SRL     = 6'b000010;
   localparam logic [5:0] c_FN_SRA     = 6'b000011;
   localparam logic [5:0] c_FN_SLLV    = 6'b000100;
   localparam logic [5:0] c_FN_SRLV    = 6'b000110;
   localparam logic [5:0] c_FN_SRAV    = 6'b000111;
   localparam logic [5:0] c_FN_SYNC    = 6'b001111;
   localparam logic [5:0] c_FN_AND     = 6'b100100;
   localparam logic [5:0] c_FN_OR      = 6'b100101;
   localparam logic [5:0] c_FN_XOR     = 6'b100110;
   localparam logic [5:0] c_FN_NOR     = 6'b100111;

   localparam logic [7:0] c_EXE_NOP_OP = 8'b00000000;
   localparam logic [7:0] c_EXE_AND_OP = 8'b00100100;
   localparam logic [7:0] c_EXE_OR_OP  = 8'b00100101;
   localparam logic [7:0] c_EXE_XOR_OP = 8'b00100110;
   localparam logic [7:0] c_EXE_NOR_OP = 8'b00100111;
   localparam logic [7:0] c_EXE_SLL_OP = 8'b01111100;
   localparam logic [7:0] c_EXE_SRL_OP = 8'b00000010;
   localparam logic [7:0] c_EXE_SRA_OP = 8'b00000011;

   localparam logic [2:0] c_EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] c_EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] c_EXE_RES_SHIFT = 3'b010;

   typedef struct packed {
      logic              valid;
      logic [7:0]        aluop;
      logic [2:0]        alusel;
      logic [DATA_W-1:0] reg1;
      logic [DATA_W-1:0] reg2;
      logic [REG_AW-1:0] wd;
      logic              wreg;
      logic [DATA_W-1:0] pc;
      logic              inv;
   } idex_t;

   idex_t idex_q, idex_d;

   logic [5:0]        w_op, w_funct;
   logic [4:0]        w_sa;
   logic [7:0]        w_aluop;
   logic [2:0]        w_alusel;
   logic [1:0]        w_rd;
   logic              w_wreg;
   logic [REG_AW-1:0] w_wd;
   logic [DATA_W-1:0] w_imm;
   logic              w_inv;

   assign w_op    = inst_i[31:26];
   assign w_funct = inst_i[5:0];
   assign w_sa    = inst_i[10:6];

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_aluop  = c_EXE_NOP_OP;
      w_alusel = c_EXE_RES_NOP;
      w_rd     = 2'b00;
      w_wreg   = 1'b0;
      w_wd     = '0;
      w_imm    = '0;
      w_inv    = 1'b1;
      case (w_op)
         c_OP_ORI, c_OP_ANDI, c_OP_XORI: begin
            w_aluop   = (w_op == c_OP_ORI)  ? c_EXE_OR_OP  :
                        (w_op == c_OP_ANDI) ? c_EXE_AND_OP : c_EXE_XOR_OP;
            w_alusel  = c_EXE_RES_LOGIC;
            w_rd      = 2'b01;
            w_wreg    = 1'b1;
            w_wd      = REG_AW'(inst_i[20:16]);
            w_imm[15:0] = inst_i[15:0];
            w_inv     = 1'b0;
         end
         c_OP_LUI: begin
            w_aluop   = c_EXE_OR_OP;
            w_alusel  = c_EXE_RES_LOGIC;
            w_rd      = 2'b01;
            w_wreg    = 1'b1;
            w_wd      = REG_AW'(inst_i[20:16]);
            w_imm[31:16] = inst_i[15:0];
            w_inv     = 1'b0;
         end
         c_OP_PREF: w_inv = 1'b0;
         c_OP_SPECIAL: begin
            if (w_sa == 5'd0) begin
               case (w_funct)
                  c_FN_OR, c_FN_AND, c_FN_XOR, c_FN_NOR: begin
                     w_aluop  = (w_funct == c_FN_OR)  ? c_EXE_OR_OP  :
                                (w_funct == c_FN_AND) ? c_EXE_AND_OP :
                                (w_funct == c_FN_XOR) ? c_EXE_XOR_OP : c_EXE_NOR_OP;
                     w_alusel = c_EXE_RES_LOGIC;
                     w_rd     = 2'b11;
                     w_wreg   = 1'b1;
                     w_wd     = REG_AW'(inst_i[15:11]);
                     w_inv    = 1'b0;
                  end
                  c_FN_SLLV, c_FN_SRLV, c_FN_SRAV: begin
                     w_aluop  = (w_funct == c_FN_SLLV) ? c_EXE_SLL_OP :
                                (w_funct == c_FN_SRLV) ? c_EXE_SRL_OP : c_EXE_SRA_OP;
                     w_alusel = c_EXE_RES_SHIFT;
                     w_rd     = 2'b11;
                     w_wreg   = 1'b1;
                     w_wd     = REG_AW'(inst_i[15:11]);
                     w_inv    = 1'b0;
                  end
                  c_FN_SYNC: w_inv = 1'b0;
                  default: ;
               endcase
            end
            // Immediate shifts: sa is a non-zero field here, so they need rs == 0.
            if (inst_i[25:21] == 5'd0 &&
                (w_funct == c_FN_SLL || w_funct == c_FN_SRL || w_funct == c_FN_SRA)) begin
               w_aluop  = (w_funct == c_FN_SLL) ? c_EXE_SLL_OP :
                          (w_funct == c_FN_SRL) ? c_EXE_SRL_OP : c_EXE_SRA_OP;
               w_alusel = c_EXE_RES_SHIFT;
               w_rd     = 2'b10;
               w_wreg   = 1'b1;
               w_wd     = REG_AW'(inst_i[15:11]);
               w_imm[4:0] = w_sa;
               w_inv    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign reg1_read_o = !Rst && w_rd[0];
   assign reg2_read_o = !Rst && w_rd[1];
   assign reg1_addr_o = Rst ? '0 : REG_AW'(inst_i[25:21]);
   assign reg2_addr_o = Rst ? '0 : REG_AW'(inst_i[20:16]);

   // ---------------------------------------------------- operand resolution
   logic [REG_AW-1:0] w_fwd_wd    [FWD_PORTS];
   logic [DATA_W-1:0] w_fwd_wdata [FWD_PORTS];

   for (genvar g = 0; g < FWD_PORTS; g++) begin : g_fwd_unpack
      assign w_fwd_wd[g]    = fwd_wd_i[g*REG_AW +: REG_AW];
      assign w_fwd_wdata[g] = fwd_wdata_i[g*DATA_W +: DATA_W];
   end

   logic [REG_AW-1:0] w_addr  [2];
   logic [DATA_W-1:0] w_rf    [2];
   logic [DATA_W-1:0] w_fdata [2];
   logic [DATA_W-1:0] w_opnd  [2];
   logic [1:0]        w_hit, w_hload, w_live, w_haz;
   logic              w_stall;

   assign w_addr[0] = REG_AW'(inst_i[25:21]);
   assign w_addr[1] = REG_AW'(inst_i[20:16]);
   assign w_rf[0]   = reg1_data_i;
   assign w_rf[1]   = reg2_data_i;

   always_comb begin
      for (int j = 0; j < 2; j++) begin
         w_hit[j]   = 1'b0;
         w_hload[j] = 1'b0;
         w_fdata[j] = '0;
         // Descending scan so the youngest (lowest-index) match wins.
         for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && (w_fwd_wd[i] == w_addr[j])) begin
               w_hit[j]   = 1'b1;
               w_hload[j] = fwd_load_i[i];
               w_fdata[j] = w_fwd_wdata[i];
            end
         end
         w_live[j] = w_rd[j] && (w_addr[j] != '0);
`ifdef ID_PIPE_FWD_EN
         w_haz[j] = w_live[j] && w_hit[j] && w_hload[j];
         if (!w_rd[j])             w_opnd[j] = w_imm;
         else if (w_addr[j] == '0) w_opnd[j] = '0;
         else if (w_hit[j])        w_opnd[j] = w_fdata[j];
         else                      w_opnd[j] = w_rf[j];
`else
         w_haz[j] = w_live[j] && w_hit[j];
         if (!w_rd[j])             w_opnd[j] = w_imm;
         else if (w_addr[j] == '0) w_opnd[j] = '0;
         else                      w_opnd[j] = w_rf[j];
`endif
      end
   end

`ifndef ID_PIPE_FWD_EN
   logic w_unused_fwd;
   assign w_unused_fwd = ^{w_hload, w_fdata[0], w_fdata[1]};
`endif

   assign w_stall = in_valid && (|w_haz);

   // ------------------------------------------------------- ID/EX register
   logic w_adv, w_take;

   assign w_adv    = !idex_q.valid || out_ready;
   assign w_take   = in_valid && !w_stall;
   assign in_ready = !Rst && (flush_i || (w_adv && !w_stall));

   always_comb begin
      idex_d = idex_q;
      if (flush_i) begin
         idex_d = '0;
      end else if (w_adv) begin
         idex_d = '0;
         if (w_take) begin
            idex_d.valid  = 1'b1;
            idex_d.aluop  = w_aluop;
            idex_d.alusel = w_alusel;
            idex_d.reg1   = w_opnd[0];
            idex_d.reg2   = w_opnd[1];
            idex_d.wd     = w_wd;
            idex_d.wreg   = w_wreg;
            idex_d.pc     = pc_i;
            idex_d.inv    = w_inv;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign out_valid      = idex_q.valid;
   assign aluop_o        = idex_q.aluop;
   assign alusel_o       = idex_q.alusel;
   assign reg1_o         = idex_q.reg1;
   assign reg2_o         = idex_q.reg2;
   assign wd_o           = idex_q.wd;
   assign wreg_o         = idex_q.wreg;
   assign pc_o           = idex_q.pc;
   assign inst_invalid_o = idex_q.inv;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// tb_id_pipe: scoreboard bench for id_pipe; expectations are pushed on accept
// and popped by a monitor on every EX transfer. Covers both ID_PIPE_FWD_EN builds.
module tb_id_pipe;
   localparam logic [7:0] c_NOP = 8'h00, c_AND = 8'h24, c_OR = 8'h25, c_XOR = 8'h26;
   localparam logic [7:0] c_NOR = 8'h27, c_SLL = 8'h7C, c_SRL = 8'h02, c_SRA = 8'h03;
   localparam logic [2:0] c_RNOP = 3'd0, c_RLOG = 3'd1, c_RSH = 3'd2;

   logic        Clk = 1'b0, Rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] pc_i = '0, inst_i = '0;
   logic        reg1_read_o, reg2_read_o;
   logic [4:0]  reg1_addr_o, reg2_addr_o;
   logic [31:0] reg1_data_i = '0, reg2_data_i = '0;
   logic [1:0]  fwd_wreg_i = '0, fwd_load_i = '0;
   logic [9:0]  fwd_wd_i = '0;
   logic [63:0] fwd_wdata_i = '0;
   logic        flush_i = 1'b0, out_valid, out_ready = 1'b1;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] reg1_o, reg2_o, pc_o;
   logic [4:0]  wd_o;
   logic        wreg_o, inst_invalid_o;

   id_pipe #(.DATA_W(32), .REG_AW(5), .FWD_PORTS(2)) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_wreg_i(fwd_wreg_i), .fwd_load_i(fwd_load_i),
      .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
      .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1, r2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] pc;
      logic        inv;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   function automatic exp_t mk(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] pc, input logic inv);
      exp_t e;
      e.aluop = op; e.alusel = sel; e.r1 = r1; e.r2 = r2;
      e.wd = wd; e.wreg = wreg; e.pc = pc; e.inv = inv;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: one comparison per EX transfer.
   always @(negedge Clk) begin
      if (!Rst && out_valid && out_ready) begin
         exp_t e;
         tests++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL out_unexpected: pc=0x%08h aluop=0x%02h, expected no output", pc_o, aluop_o);
         end else begin
            e = sb.pop_front();
            if (aluop_o !== e.aluop || alusel_o !== e.alusel || reg1_o !== e.r1 ||
                reg2_o !== e.r2 || wd_o !== e.wd || wreg_o !== e.wreg ||
                pc_o !== e.pc || inst_invalid_o !== e.inv) begin
               failed++;
               $display("FAIL out_pc%08h: got op=%02h sel=%0d r1=%08h r2=%08h wd=%0d wreg=%0d pc=%08h inv=%0d, expected op=%02h sel=%0d r1=%08h r2=%08h wd=%0d wreg=%0d pc=%08h inv=%0d",
                        e.pc, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o,
                        e.aluop, e.alusel, e.r1, e.r2, e.wd, e.wreg, e.pc, e.inv);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      int n = 0;
      in_valid = 1'b1; inst_i = inst; pc_i = pc;
      @(negedge Clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge Clk);
      end
      tests++;
      if (!in_ready) begin
         failed++;
         $display("FAIL accept_pc%08h: in_ready stuck at 0, expected 1 within 20 cycles", pc);
      end else begin
         sb.push_back(e);
      end
      @(posedge Clk); #1;
      in_valid = 1'b0; inst_i = '0;
   endtask

   task automatic stall_check(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge Clk);
         chk(name, {31'd0, in_ready}, 32'd0);
         if (k > 0) chk({name, "_bubble"}, {31'd0, out_valid}, 32'd0);
         @(posedge Clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      inst_i = 32'h34011100;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_aluop",     {24'd0, aluop_o}, 0);
      chk("rst_reg2",      reg2_o, 0);
      chk("rst_wd_wreg",   {26'd0, wd_o, wreg_o}, 0);
      chk("rst_pc_inv",    pc_o ^ {31'd0, inst_invalid_o}, 0);
      chk("rst_rd_en",     {30'd0, reg1_read_o, reg2_read_o}, 0);
      chk("rst_addr",      {22'd0, reg1_addr_o, reg2_addr_o}, 0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("ori_rd_en", {30'd0, reg1_read_o, reg2_read_o}, 32'b10);
      chk("ori_addr2", {27'd0, reg2_addr_o}, 1);
      @(posedge Clk); #1;

      // ori $1,$0,0x1100
      send(32'h34011100, 32'h100, mk(c_OR, c_RLOG, 0, 32'h1100, 1, 1, 32'h100, 0));

      // or $3,$1,$2 with both ports writing $1
      fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1};
      fwd_wdata_i = {32'h00005555, 32'hAAAA0000};
      reg1_data_i = 32'h12345678; reg2_data_i = 32'h0000000F;
`ifdef ID_PIPE_FWD_EN
      send(32'h00221825, 32'h104, mk(c_OR, c_RLOG, 32'hAAAA0000, 32'h0F, 3, 1, 32'h104, 0));
`else
      in_valid = 1'b1; inst_i = 32'h00221825; pc_i = 32'h104;
      stall_check("nofwd_or_stall", 2);
      fwd_wreg_i = 2'b00;
      send(32'h00221825, 32'h104, mk(c_OR, c_RLOG, 32'h12345678, 32'h0F, 3, 1, 32'h104, 0));
`endif
      fwd_wreg_i = 2'b00;

      // sll $2,$1,4 behind a load on port 1
      fwd_wreg_i = 2'b10; fwd_load_i = 2'b10; fwd_wd_i = {5'd1, 5'd0};
      fwd_wdata_i = {32'hCAFE0001, 32'h0}; reg2_data_i = 32'h00000077;
      in_valid = 1'b1; inst_i = 32'h00011100; pc_i = 32'h108;
      stall_check("lu_stall", 2);
`ifdef ID_PIPE_FWD_EN
      fwd_load_i = 2'b00;
      send(32'h00011100, 32'h108, mk(c_SLL, c_RSH, 4, 32'hCAFE0001, 2, 1, 32'h108, 0));
`else
      fwd_load_i = 2'b00; fwd_wreg_i = 2'b00;
      send(32'h00011100, 32'h108, mk(c_SLL, c_RSH, 4, 32'h77, 2, 1, 32'h108, 0));
`endif
      fwd_wreg_i = 2'b00; fwd_load_i = 2'b00;

      // Forwarding never matches $0, even with a load flagged
      fwd_wreg_i = 2'b01; fwd_load_i = 2'b01; fwd_wd_i = '0; fwd_wdata_i = {32'h0, 32'hDEADBEEF};
      send(32'h340B0005, 32'h10C, mk(c_OR, c_RLOG, 0, 5, 11, 1, 32'h10C, 0));
      fwd_wreg_i = 2'b00; fwd_load_i = 2'b00;

      // Assorted encodings from the regfile
      reg1_data_i = 32'h0000FFFF; reg2_data_i = 32'h00FF00FF;
      send(32'h00224027, 32'h110, mk(c_NOR, c_RLOG, 32'hFFFF, 32'h00FF00FF, 8, 1, 32'h110, 0));
      send(32'h00224807, 32'h114, mk(c_SRA, c_RSH, 32'hFFFF, 32'h00FF00FF, 9, 1, 32'h114, 0));
      send(32'h000257C2, 32'h118, mk(c_SRL, c_RSH, 31, 32'h00FF00FF, 10, 1, 32'h118, 0));
      send(32'h0000000F, 32'h11C, mk(c_NOP, c_RNOP, 0, 0, 0, 0, 32'h11C, 0));
      send(32'h00211100, 32'h120, mk(c_NOP, c_RNOP, 0, 0, 0, 0, 32'h120, 1));
      send(32'hFC000000, 32'h124, mk(c_NOP, c_RNOP, 0, 0, 0, 0, 32'h124, 1));
      send(32'h3C051234, 32'h128, mk(c_OR, c_RLOG, 0, 32'h12340000, 5, 1, 32'h128, 0));

      // Backpressure hold, then flush
      @(posedge Clk); #1;
      out_ready = 1'b0;
      send(32'h3806FFFF, 32'h200, mk(c_XOR, c_RLOG, 0, 32'hFFFF, 6, 1, 32'h200, 0));
      in_valid = 1'b1; inst_i = 32'h300700F0; pc_i = 32'h204;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk("bp_in_ready", {31'd0, in_ready}, 0);
         chk("bp_valid",    {31'd0, out_valid}, 1);
         chk("bp_reg2",     reg2_o, 32'hFFFF);
         chk("bp_wd_pc",    {wd_o, pc_o[26:0]}, {5'd6, 27'h200});
         @(posedge Clk); #1;
      end
      flush_i = 1'b1;
      @(negedge Clk);
      chk("flush_in_ready", {31'd0, in_ready}, 1);
      @(posedge Clk); #1;
      if (sb.size() != 0) sb.delete(sb.size() - 1);
      flush_i = 1'b0; in_valid = 1'b0;
      @(negedge Clk);
      chk("flush_bubble", {31'd0, out_valid}, 0);
      @(posedge Clk); #1;
      out_ready = 1'b1;

      // and $4,$1,$1 against a non-load producer on port 0
      fwd_wreg_i = 2'b01; fwd_load_i = 2'b00; fwd_wd_i = {5'd0, 5'd1};
      fwd_wdata_i = {32'h0, 32'hBEEF0000};
      reg1_data_i = 32'h33; reg2_data_i = 32'h44;
`ifdef ID_PIPE_FWD_EN
      send(32'h00212024, 32'h300, mk(c_AND, c_RLOG, 32'hBEEF0000, 32'hBEEF0000, 4, 1, 32'h300, 0));
`else
      in_valid = 1'b1; inst_i = 32'h00212024; pc_i = 32'h300;
      stall_check("nofwd_and_stall", 3);
      fwd_wreg_i = 2'b00;
      send(32'h00212024, 32'h300, mk(c_AND, c_RLOG, 32'h33, 32'h44, 4, 1, 32'h300, 0));
`endif
      fwd_wreg_i = 2'b00;

      // Reset during backpressure discards the held instruction
      @(posedge Clk); #1;
      out_ready = 1'b0;
      send(32'h34011100, 32'h400, mk(c_OR, c_RLOG, 0, 32'h1100, 1, 1, 32'h400, 0));
      @(posedge Clk); #1;
      Rst = 1'b1; in_valid = 1'b1; inst_i = 32'h34011100;
      @(negedge Clk);
      chk("rst_mid_rd_en", {30'd0, reg1_read_o, reg2_read_o}, 0);
      @(posedge Clk); #1;
      sb.delete();
      Rst = 1'b0; in_valid = 1'b0; inst_i = '0;
      @(negedge Clk);
      chk("rst_mid_valid", {31'd0, out_valid}, 0);
      chk("rst_mid_reg2",  reg2_o, 0);
      @(posedge Clk); #1;
      out_ready = 1'b1;

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
